// File: rtl/xilinx_assignment3.sv
// 1-D convolution demo: internal ramp/LFSR producer feeding a 4-tap FIR, one-cycle latency, ready drops for one stall cycle per 16-sample packet.
// Define CONV_SATURATE_EN to clamp overflowing Y to 0xFFFF; otherwise Y keeps the low 16 bits.
module xilinx_assignment3 (
  input  logic        clk,
  input  logic        Reset_in,
  input  logic        Test,
  output logic        Test_Result,
  output logic        valid,
  output logic        invalid,
  output logic        finish,
  output logic        packet_Done,
  output logic        reset,
  output logic        ready,
  output logic [15:0] Y,
  output logic [15:0] HS_out,
  output logic [8:0]  count,
  output logic [3:0]  count1,
  output logic [15:0] avrg
);

  typedef enum logic [1:0] {RUN, STALL, DONE} state_t;

  state_t      state_q, state_d;
  logic        reset_q, mode_q, inv_q, pd_q, result_q;
  logic [15:0] lfsr_q, x1_q, x2_q, x3_q, y_q, avrg_q, csum_q;
  logic [19:0] acc_q;
  logic [8:0]  count_q;
  logic [3:0]  count1_q;

  logic [15:0] sample, y_new, csum_new;
  logic [18:0] sum19;
  logic [19:0] acc_new;
  logic        xfer, ovf, last_in_pkt, last_all, lfsr_fb;

  assign sample      = mode_q ? {8'h00, count_q[7:0]} : lfsr_q;
  assign valid       = !reset_q && (state_q != DONE);
  assign ready       = !reset_q && (state_q == RUN);
  assign xfer        = valid && ready;
  assign last_in_pkt = (count1_q == 4'd15);
  assign last_all    = (count_q == 9'd255);
  assign lfsr_fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // Taps 1,2,2,1; the delay line holds zeros right after reset so x[<0] = 0.
  assign sum19 = {3'b000, sample} + {2'b00, x1_q, 1'b0}
               + {2'b00, x2_q, 1'b0} + {3'b000, x3_q};
  assign ovf   = |sum19[18:16];

`ifdef CONV_SATURATE_EN
  assign y_new = ovf ? 16'hFFFF : sum19[15:0];
`else
  assign y_new = sum19[15:0];
`endif

  assign acc_new  = acc_q + {4'h0, y_new};
  assign csum_new = csum_q + y_new;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (xfer && last_in_pkt) state_d = last_all ? DONE : STALL;
      STALL:   state_d = RUN;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset_in) begin
      state_q  <= RUN;
      reset_q  <= 1'b1;
      mode_q   <= Test;
      lfsr_q   <= 16'hACE1;
      x1_q     <= '0;
      x2_q     <= '0;
      x3_q     <= '0;
      y_q      <= '0;
      avrg_q   <= '0;
      csum_q   <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      count1_q <= '0;
      inv_q    <= 1'b0;
      pd_q     <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reset_q <= 1'b0;
      inv_q   <= 1'b0;
      pd_q    <= 1'b0;
      if (xfer) begin
        x1_q     <= sample;
        x2_q     <= x1_q;
        x3_q     <= x2_q;
        lfsr_q   <= {lfsr_fb, lfsr_q[15:1]};
        y_q      <= y_new;
        inv_q    <= ovf;
        csum_q   <= csum_new;
        count_q  <= count_q + 9'd1;
        count1_q <= count1_q + 4'd1;
        if (last_in_pkt) begin
          avrg_q <= acc_new[19:4];
          acc_q  <= '0;
          pd_q   <= 1'b1;
        end else begin
          acc_q <= acc_new;
        end
        if (last_all) result_q <= mode_q && (csum_new == 16'hF40E);
      end
    end
  end

  assign HS_out      = reset_q ? 16'h0000 : sample;
  assign finish      = (state_q == DONE);
  assign Test_Result = finish && result_q;
  assign invalid     = inv_q;
  assign packet_Done = pd_q;
  assign reset       = reset_q;
  assign Y           = y_q;
  assign avrg        = avrg_q;
  assign count       = count_q;
  assign count1      = count1_q;

endmodule

// File: tb/tb_xilinx_assignment3.sv
// Directed bench for xilinx_assignment3: reset, LFSR mode vs reference model, ramp self-test, mid-run reset.
module tb_xilinx_assignment3;

  logic        clk = 1'b0;
  logic        Reset_in = 1'b0;
  logic        Test = 1'b0;
  logic        Test_Result, valid, invalid, finish, packet_Done, reset, ready;
  logic [15:0] Y, HS_out, avrg;
  logic [8:0]  count;
  logic [3:0]  count1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xilinx_assignment3 dut (
    .clk(clk), .Reset_in(Reset_in), .Test(Test), .Test_Result(Test_Result),
    .valid(valid), .invalid(invalid), .finish(finish), .packet_Done(packet_Done),
    .reset(reset), .ready(ready), .Y(Y), .HS_out(HS_out), .count(count),
    .count1(count1), .avrg(avrg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic mode);
    Reset_in = 1'b1;
    Test     = mode;
    step();
    Reset_in = 1'b0;
  endtask

  // Hand-derived ramp response: 0,1,4 then 6n-9.
  function automatic int ramp_y(input int n);
    if (n == 0) return 0;
    if (n == 1) return 1;
    if (n == 2) return 4;
    return 6 * n - 9;
  endfunction

  initial begin
    logic [15:0] m_lfsr, x0, x1, x2, x3, exp_y;
    logic [19:0] m_acc;
    logic        tx;
    int          sum, xfers, cyc, n;

    // Reset in LFSR mode
    do_reset(1'b0);
    chk("rst_reset", reset, 1);
    chk("rst_valid", valid, 0);
    chk("rst_ready", ready, 0);
    chk("rst_hs", HS_out, 0);
    chk("rst_y", Y, 0);
    chk("rst_count", count, 0);
    chk("rst_count1", count1, 0);
    chk("rst_finish", finish, 0);
    chk("rst_avrg", avrg, 0);
    chk("rst_pd", packet_Done, 0);
    chk("rst_inv", invalid, 0);
    chk("rst_tr", Test_Result, 0);
    step();
    chk("run_reset", reset, 0);
    chk("run_valid", valid, 1);
    chk("run_ready", ready, 1);
    chk("run_hs_seed", HS_out, 16'hACE1);

    // Normal mode against reference model
    m_lfsr = 16'hACE1; x1 = 0; x2 = 0; x3 = 0; m_acc = 0; xfers = 0;
    sum = 0; exp_y = 0;
    for (int c = 0; c < 400 && !finish; c++) begin
      tx = valid && ready;
      if (tx) begin
        chk("hs_lfsr", HS_out, m_lfsr);
        x0  = m_lfsr;
        sum = x0 + 2 * x1 + 2 * x2 + x3;
`ifdef CONV_SATURATE_EN
        exp_y = (sum > 65535) ? 16'hFFFF : 16'(sum);
`else
        exp_y = 16'(sum);
`endif
        x3 = x2; x2 = x1; x1 = x0;
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      end
      step();
      if (tx) begin
        chk("y_norm", Y, exp_y);
        chk("inv_norm", invalid, (sum > 65535) ? 1 : 0);
        m_acc = m_acc + 20'(exp_y);
        xfers++;
        if (xfers % 16 == 0) begin
          chk("avrg_norm", avrg, 32'(m_acc >> 4));
          m_acc = 0;
        end
      end
    end
    chk("norm_finish", finish, 1);
    chk("norm_xfers", xfers, 256);
    chk("norm_count", count, 256);
    chk("norm_tr", Test_Result, 0);

    // Ramp self-test
    do_reset(1'b1);
    step();
    cyc = 0; n = 0;
    for (int c = 0; c < 400 && !finish; c++) begin
      tx = valid && ready;
      step();
      cyc++;
      if (tx) begin
        chk("y_ramp", Y, ramp_y(n));
        chk("inv_ramp", invalid, 0);
        chk("pd_ramp", packet_Done, (n % 16 == 15) ? 1 : 0);
        if (n % 16 == 15) chk("avrg_ramp", avrg, 96 * (n / 16) + 36);
        n++;
      end else begin
        chk("pd_idle", packet_Done, 0);
      end
      if (!finish) chk("ready_stall", ready, packet_Done ? 0 : 1);
    end
    chk("ramp_cycles", cyc, 271);
    chk("ramp_finish", finish, 1);
    chk("ramp_count", count, 256);
    chk("ramp_tr", Test_Result, 1);
    chk("ramp_valid", valid, 0);
    chk("ramp_ready", ready, 0);
    chk("ramp_y_last", Y, 1521);
    chk("ramp_avrg_last", avrg, 1476);
    for (int k = 0; k < 3; k++) step();
    chk("hold_count", count, 256);
    chk("hold_finish", finish, 1);
    chk("hold_y", Y, 1521);
    chk("hold_avrg", avrg, 1476);
    chk("hold_tr", Test_Result, 1);

    // Reset in the middle of a run
    do_reset(1'b1);
    step();
    for (int c = 0; c < 200 && count != 100; c++) step();
    chk("mid_reach100", count, 100);
    Reset_in = 1'b1;
    step();
    Reset_in = 1'b0;
    chk("mid_count", count, 0);
    chk("mid_avrg", avrg, 0);
    chk("mid_finish", finish, 0);
    chk("mid_reset", reset, 1);
    chk("mid_tr", Test_Result, 0);
    for (int c = 0; c < 400 && !finish; c++) step();
    chk("mid_done_finish", finish, 1);
    chk("mid_done_count", count, 256);
    chk("mid_done_tr", Test_Result, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
